op_pkt_fifo: RTL and testbench
==============================

// Module: op_pkt_fifo
// PURPOSE
//  Buffers operation packets {mode, res, operand} from the host write port until the control FSM consumes them.
//  Sits directly upstream of the control FSM. Drives op_pkt_available and accepts the FSM's rd_fifo pop strobe.
//  Presents the popped packet on registered outputs, one cycle after the pop, for MODE_DETECT and the datapath.
// PARAMETERS
//  NUM_MODES   3   one-hot mode width (param.vh); 3'b001=EXP, 3'b010=SIN, 3'b100=COS
//  RES_WIDTH   8   term-count/resolution field width (param.vh)
//  DATA_WIDTH  16  operand x width
//  DEPTH       8   packet entries; power of 2, >=2
//  ADDR_W      $clog2(DEPTH)  derived; pointers are ADDR_W+1 bits (wrap bit)
// PORTS
//  clk               in   1           rising-edge clock
//  rst_n             in   1           synchronous active-low reset
//  in_valid          in   1           host packet valid
//  in_ready          out  1           FIFO can accept (= !full)
//  in_mode           in   NUM_MODES   packet mode
//  in_res            in   RES_WIDTH   number of series terms
//  in_x              in   DATA_WIDTH  operand
//  rd_fifo           in   1           pop strobe from control FSM
//  op_pkt_available  out  1           FIFO non-empty (= !empty)
//  pkt_mode          out  NUM_MODES   popped mode, registered
//  pkt_res           out  RES_WIDTH   popped res, registered
//  pkt_x             out  DATA_WIDTH  popped operand, registered
//  pkt_vld           out  1           1-cycle pulse: pkt_* updated this cycle
//  fill_cnt          out  ADDR_W+1    current occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): wr_ptr=rd_ptr=0, fill_cnt=0, op_pkt_available=0, in_ready=1.
//   pkt_mode/pkt_res/pkt_x=0, pkt_vld=0. Storage contents are not reset.
//  Reset mid-operation: all stored packets are discarded; pkt_* return to 0 on the same edge.
//  Write: in_valid & in_ready at an edge stores {in_mode,in_res,in_x} at wr_ptr; wr_ptr++.
//  Pop: rd_fifo & !empty at an edge loads pkt_* from rd_ptr; rd_ptr++; pkt_vld=1 on the following cycle only.
//  Pop latency: pkt_* are valid the cycle after the rd_fifo edge and hold until the next successful pop.
//  Empty: full = (ptr MSBs differ & low bits equal); empty = (ptrs equal). Both are combinational from registered pointers.
//  Pop while empty is ignored: pointers, pkt_* and pkt_vld=0 are unchanged, and the underflow sticky is set (see CONFIGURATION).
//  Full: in_ready=0; in_valid is held by the host (no drop). No write pass-through when full, even with a simultaneous pop.
//  Simultaneous write+pop, non-empty and non-full: both occur; fill_cnt is unchanged.
//  Simultaneous write+pop while empty: the write is accepted and the pop is ignored (no bypass). op_pkt_available rises the next cycle.
//  Pointer wrap: the low ADDR_W bits wrap DEPTH-1 -> 0 and the MSB toggles. fill_cnt = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
//  Contents are not checked: a non-one-hot mode or res<2 is stored and popped unchanged. The FSM rejects bad modes.
//  Ordering is strict FIFO; there is no reorder or flush other than reset.
// CONFIGURATION
//  OP_PKT_FIFO_STATS_EN defined adds outputs:
//   acc_cnt   out  16  accepted-packet count; saturates at 16'hFFFF; reset 0
//   underflow out  1   sticky, set by a pop while empty; cleared only by reset
//  OP_PKT_FIFO_STATS_EN undefined: these ports and their logic are absent; underflow pops are silently ignored.
// STRUCTURE
//  param.vh: NUM_MODES, RES_WIDTH, mode encodings MODE_EXP/MODE_SIN/MODE_COS.
//   Also holds the packet width localparam OP_PKT_W = NUM_MODES+RES_WIDTH+DATA_WIDTH.
//  Sub-module op_pkt_fifo_mem: DEPTH x OP_PKT_W register array with 1 write port and a synchronous read port.
//   Pointer, flag and output-register logic stays in op_pkt_fifo.
// TESTING
//  1 Reset then idle: op_pkt_available=0, in_ready=1, fill_cnt=0, pkt_*=0.
//  2 Write {001,8'd10,16'h1234}, then pop one cycle later -> next cycle pkt_vld=1, pkt_mode=001, pkt_res=10, pkt_x=16'h1234; op_pkt_available=0.
//  3 Write 8 packets back-to-back -> after the 8th, in_ready=0, fill_cnt=8.
//   A 9th in_valid is held until one pop; then it is accepted; pops return all 9 in order.
//  4 Write 5 packets, pop 5, write 6, pop 6 (pointer wrap) -> data order preserved; fill_cnt returns to 0.
//  5 Pop while empty -> no pkt_vld, pkt_* unchanged; with OP_PKT_FIFO_STATS_EN, underflow=1 until reset.
//  6 fill_cnt=3, then rst_n=0 for one edge -> fill_cnt=0 and pkt_*=0; the next pop after reset is ignored.

Source files
------------

// File: rtl/op_pkt_fifo_pkg.sv
// Shared widths and mode encodings for the operation packet FIFO.
// Imported by op_pkt_fifo and op_pkt_fifo_mem.
package op_pkt_fifo_pkg;

  localparam int NUM_MODES      = 3;
  localparam int RES_WIDTH      = 8;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH      = 8;

  localparam logic [NUM_MODES-1:0] MODE_EXP = 3'b001;
  localparam logic [NUM_MODES-1:0] MODE_SIN = 3'b010;
  localparam logic [NUM_MODES-1:0] MODE_COS = 3'b100;

  localparam int OP_PKT_W =
    NUM_MODES + RES_WIDTH + DEF_DATA_WIDTH;

  function automatic int pkt_w(input int dw);
    return NUM_MODES + RES_WIDTH + dw;
  endfunction

endpackage

// File: rtl/op_pkt_fifo_mem.sv
// Packet storage: DEPTH x W register array, one write port,
// one synchronous read port whose register clears on reset.
module op_pkt_fifo_mem
  import op_pkt_fifo_pkg::*;
#(
  parameter int W      = OP_PKT_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [W-1:0]      wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [W-1:0]      rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/op_pkt_fifo.sv
// Operation packet FIFO in front of the control FSM.
// Optional OP_PKT_FIFO_STATS_EN adds acc_cnt and underflow outputs.
module op_pkt_fifo
  import op_pkt_fifo_pkg::*;
#(
  parameter int    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int    DEPTH      = DEF_DEPTH,
  localparam int   ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_MODES-1:0]  in_mode,
  input  logic [RES_WIDTH-1:0]  in_res,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic                  rd_fifo,
  output logic                  op_pkt_available,
  output logic [NUM_MODES-1:0]  pkt_mode,
  output logic [RES_WIDTH-1:0]  pkt_res,
  output logic [DATA_WIDTH-1:0] pkt_x,
  output logic                  pkt_vld,
`ifdef OP_PKT_FIFO_STATS_EN
  output logic [15:0]           acc_cnt,
  output logic                  underflow,
`endif
  output logic [ADDR_W:0]       fill_cnt
);

  localparam int PW = pkt_w(DATA_WIDTH);

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            vld_q;
  logic            full, empty;
  logic            we, re;
  logic [PW-1:0]   rdata;

  assign full = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign we = in_valid && !full;
  assign re = rd_fifo && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (we) wr_ptr_d = wr_ptr_q + 1'b1;
    if (re) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= re;
    end
  end

  op_pkt_fifo_mem #(
    .W     (PW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i ({in_mode, in_res, in_x}),
    .re_i    (re),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rdata)
  );

  assign in_ready         = !full;
  assign op_pkt_available = !empty;
  assign fill_cnt         = wr_ptr_q - rd_ptr_q;
  assign pkt_vld          = vld_q;
  assign pkt_mode = rdata[PW-1 -: NUM_MODES];
  assign pkt_res  = rdata[DATA_WIDTH +: RES_WIDTH];
  assign pkt_x    = rdata[DATA_WIDTH-1:0];

`ifdef OP_PKT_FIFO_STATS_EN
  logic [15:0] acc_cnt_q, acc_cnt_d;
  logic        uflow_q, uflow_d;

  always_comb begin
    acc_cnt_d = acc_cnt_q;
    uflow_d   = uflow_q;
    if (we && acc_cnt_q != 16'hFFFF)
      acc_cnt_d = acc_cnt_q + 16'd1;
    if (rd_fifo && empty)
      uflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_cnt_q <= '0;
      uflow_q   <= 1'b0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
      uflow_q   <= uflow_d;
    end
  end

  assign acc_cnt   = acc_cnt_q;
  assign underflow = uflow_q;
`endif

endmodule

// File: tb/tb_op_pkt_fifo.sv
// Randomized self-checking bench for op_pkt_fifo against a
// queue-based packet model.
module tb_op_pkt_fifo;

  localparam int NM = 3;
  localparam int RW = 8;
  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NM-1:0] in_mode = '0;
  logic [RW-1:0] in_res = '0;
  logic [DW-1:0] in_x = '0;
  logic          rd_fifo = 1'b0;
  logic          op_pkt_available;
  logic [NM-1:0] pkt_mode;
  logic [RW-1:0] pkt_res;
  logic [DW-1:0] pkt_x;
  logic          pkt_vld;
  logic [AW:0]   fill_cnt;
`ifdef OP_PKT_FIFO_STATS_EN
  logic [15:0]   acc_cnt;
  logic          underflow;
`endif

  always #5 clk = ~clk;

  op_pkt_fifo dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_mode          (in_mode),
    .in_res           (in_res),
    .in_x             (in_x),
    .rd_fifo          (rd_fifo),
    .op_pkt_available (op_pkt_available),
    .pkt_mode         (pkt_mode),
    .pkt_res          (pkt_res),
    .pkt_x            (pkt_x),
    .pkt_vld          (pkt_vld),
`ifdef OP_PKT_FIFO_STATS_EN
    .acc_cnt          (acc_cnt),
    .underflow        (underflow),
`endif
    .fill_cnt         (fill_cnt)
  );

  int n_chk = 0;
  int n_bad = 0;

  logic [NM+RW+DW-1:0] q[$];
  logic [NM-1:0] e_mode = '0;
  logic [RW-1:0] e_res = '0;
  logic [DW-1:0] e_x = '0;
  logic          e_vld = 1'b0;
  logic          e_uf = 1'b0;
  int            e_acc = 0;

  // Drive one cycle from a negedge; update the model at the edge.
  task automatic cyc(input logic v, input logic [NM-1:0] m,
                     input logic [RW-1:0] r, input logic [DW-1:0] x,
                     input logic pop);
    logic [NM+RW+DW-1:0] e;
    logic acc, pok;
    in_valid = v; in_mode = m; in_res = r; in_x = x;
    rd_fifo = pop;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      e_mode = '0; e_res = '0; e_x = '0;
      e_vld = 0; e_uf = 0; e_acc = 0;
    end else begin
      acc = v && (q.size() < DEPTH);
      pok = pop && (q.size() > 0);
      if (pop && q.size() == 0) e_uf = 1;
      e_vld = pok;
      if (pok) begin
        e = q.pop_front();
        {e_mode, e_res, e_x} = e;
      end
      if (acc) begin
        q.push_back({m, r, x});
        if (e_acc != 65535) e_acc++;
      end
    end
    @(negedge clk);
    in_valid = 0; rd_fifo = 0;
  endtask

  task automatic idle();
    cyc(0, '0, '0, '0, 0);
  endtask

  task automatic wr_rand();
    cyc(1, 3'($urandom), 8'($urandom), 16'($urandom), 0);
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle(); idle();
    rst_n = 1;
    idle();
    n_chk++;
    if (op_pkt_available !== 1'b0) begin
      n_bad++; $display("FAIL reset_avail got=%b exp=0", op_pkt_available);
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready got=%b exp=1", in_ready);
    end
    n_chk++;
    if (fill_cnt !== '0) begin
      n_bad++; $display("FAIL reset_fill got=%0d exp=0", fill_cnt);
    end
    n_chk++;
    if ({pkt_mode, pkt_res, pkt_x, pkt_vld} !== '0) begin
      n_bad++;
      $display("FAIL reset_pkt got=%h/%h/%h/%b exp=0",
               pkt_mode, pkt_res, pkt_x, pkt_vld);
    end
  endtask

  task automatic test_single();
    cyc(1, 3'b001, 8'd10, 16'h1234, 0);
    n_chk++;
    if (op_pkt_available !== 1'b1 || fill_cnt !== 4'd1) begin
      n_bad++;
      $display("FAIL single_wr got avail=%b fill=%0d exp 1/1",
               op_pkt_available, fill_cnt);
    end
    cyc(0, '0, '0, '0, 1);
    n_chk++;
    if (pkt_vld !== 1'b1 || pkt_mode !== 3'b001 ||
        pkt_res !== 8'd10 || pkt_x !== 16'h1234) begin
      n_bad++;
      $display("FAIL single_pop got vld=%b %b/%0d/%h exp 1 001/10/1234",
               pkt_vld, pkt_mode, pkt_res, pkt_x);
    end
    n_chk++;
    if (op_pkt_available !== 1'b0) begin
      n_bad++; $display("FAIL single_avail got=%b exp=0", op_pkt_available);
    end
    idle();
    n_chk++;
    if (pkt_vld !== 1'b0 || pkt_x !== 16'h1234) begin
      n_bad++;
      $display("FAIL single_hold got vld=%b x=%h exp 0 1234", pkt_vld, pkt_x);
    end
  endtask

  task automatic test_full();
    logic [NM-1:0] m9;
    logic [RW-1:0] r9;
    logic [DW-1:0] x9;
    m9 = 3'($urandom); r9 = 8'($urandom); x9 = 16'($urandom);
    for (int i = 0; i < DEPTH; i++) wr_rand();
    n_chk++;
    if (in_ready !== 1'b0 || fill_cnt !== 4'd8) begin
      n_bad++;
      $display("FAIL full got ready=%b fill=%0d exp 0/8", in_ready, fill_cnt);
    end
    for (int i = 0; i < 3; i++) cyc(1, m9, r9, x9, 0);
    n_chk++;
    if (fill_cnt !== 4'd8) begin
      n_bad++; $display("FAIL full_hold got fill=%0d exp=8", fill_cnt);
    end
    cyc(1, m9, r9, x9, 1);
    n_chk++;
    if (fill_cnt !== 4'd7 || pkt_vld !== 1'b1 || pkt_x !== e_x) begin
      n_bad++;
      $display("FAIL full_pop got fill=%0d vld=%b x=%h exp 7/1/%h",
               fill_cnt, pkt_vld, pkt_x, e_x);
    end
    cyc(1, m9, r9, x9, 0);
    n_chk++;
    if (fill_cnt !== 4'd8) begin
      n_bad++; $display("FAIL full_ninth got fill=%0d exp=8", fill_cnt);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, '0, '0, '0, 1);
      n_chk++;
      if ({pkt_vld, pkt_mode, pkt_res, pkt_x} !==
          {e_vld, e_mode, e_res, e_x}) begin
        n_bad++;
        $display("FAIL full_drain%0d got %b %h/%h/%h exp %b %h/%h/%h", i,
                 pkt_vld, pkt_mode, pkt_res, pkt_x, e_vld, e_mode, e_res, e_x);
      end
    end
    n_chk++;
    if (pkt_x !== x9 || pkt_mode !== m9 || pkt_res !== r9 ||
        fill_cnt !== '0) begin
      n_bad++;
      $display("FAIL full_last got %h/%h/%h fill=%0d exp %h/%h/%h 0",
               pkt_mode, pkt_res, pkt_x, fill_cnt, m9, r9, x9);
    end
  endtask

  task automatic test_wrap();
    int rounds[2] = '{5, 6};
    foreach (rounds[k]) begin
      for (int i = 0; i < rounds[k]; i++) wr_rand();
      for (int i = 0; i < rounds[k]; i++) begin
        cyc(0, '0, '0, '0, 1);
        n_chk++;
        if (pkt_vld !== 1'b1 ||
            {pkt_mode, pkt_res, pkt_x} !== {e_mode, e_res, e_x}) begin
          n_bad++;
          $display("FAIL wrap%0d_%0d got %b %h/%h/%h exp 1 %h/%h/%h", k, i,
                   pkt_vld, pkt_mode, pkt_res, pkt_x, e_mode, e_res, e_x);
        end
      end
    end
    n_chk++;
    if (fill_cnt !== '0 || op_pkt_available !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_end got fill=%0d avail=%b exp 0/0",
               fill_cnt, op_pkt_available);
    end
  endtask

  task automatic test_underflow();
    logic [NM+RW+DW-1:0] prev;
    prev = {pkt_mode, pkt_res, pkt_x};
    cyc(0, '0, '0, '0, 1);
    n_chk++;
    if (pkt_vld !== 1'b0 || {pkt_mode, pkt_res, pkt_x} !== prev ||
        fill_cnt !== '0) begin
      n_bad++;
      $display("FAIL uflow got vld=%b pkt=%h fill=%0d exp 0 %h 0",
               pkt_vld, {pkt_mode, pkt_res, pkt_x}, fill_cnt, prev);
    end
    idle();
`ifdef OP_PKT_FIFO_STATS_EN
    n_chk++;
    if (underflow !== e_uf || acc_cnt !== 16'(e_acc)) begin
      n_bad++;
      $display("FAIL uflow_stats got uf=%b acc=%0d exp %b %0d",
               underflow, acc_cnt, e_uf, e_acc);
    end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) wr_rand();
    cyc(0, '0, '0, '0, 1);
    wr_rand();
    n_chk++;
    if (fill_cnt !== 4'd3) begin
      n_bad++; $display("FAIL rmid_fill got=%0d exp=3", fill_cnt);
    end
    rst_n = 0;
    idle();
    rst_n = 1;
    n_chk++;
    if (fill_cnt !== '0 || {pkt_mode, pkt_res, pkt_x, pkt_vld} !== '0) begin
      n_bad++;
      $display("FAIL rmid_clr got fill=%0d pkt=%h exp 0 0",
               fill_cnt, {pkt_mode, pkt_res, pkt_x});
    end
    cyc(0, '0, '0, '0, 1);
    n_chk++;
    if (pkt_vld !== 1'b0 || fill_cnt !== '0 || pkt_x !== '0) begin
      n_bad++;
      $display("FAIL rmid_pop got vld=%b fill=%0d x=%h exp 0 0 0",
               pkt_vld, fill_cnt, pkt_x);
    end
`ifdef OP_PKT_FIFO_STATS_EN
    rst_n = 0; idle(); rst_n = 1; idle();
    n_chk++;
    if (underflow !== 1'b0 || acc_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL rmid_stats got uf=%b acc=%0d exp 0 0", underflow, acc_cnt);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 99) < 60), 3'($urandom), 8'($urandom),
          16'($urandom), 1'($urandom_range(0, 99) < 50));
      n_chk++;
      if (fill_cnt !== 4'(q.size()) ||
          in_ready !== (q.size() < DEPTH) ||
          op_pkt_available !== (q.size() > 0) ||
          {pkt_vld, pkt_mode, pkt_res, pkt_x} !==
          {e_vld, e_mode, e_res, e_x}) begin
        n_bad++;
        $display("FAIL rand%0d got fill=%0d rdy=%b av=%b %b %h/%h/%h exp fill=%0d %b %h/%h/%h",
                 i, fill_cnt, in_ready, op_pkt_available, pkt_vld,
                 pkt_mode, pkt_res, pkt_x, q.size(), e_vld,
                 e_mode, e_res, e_x);
      end
`ifdef OP_PKT_FIFO_STATS_EN
      n_chk++;
      if (underflow !== e_uf || acc_cnt !== 16'(e_acc)) begin
        n_bad++;
        $display("FAIL rand_stats%0d got uf=%b acc=%0d exp %b %0d",
                 i, underflow, acc_cnt, e_uf, e_acc);
      end
`endif
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
